// File: rtl/output_module_304to16.sv
// Parallel-to-serial output stage: one 304-bit word in over valid/ready,
// 19 x 16-bit chunks out MSB-first, then a one-cycle done pulse.
module output_module_304to16 #(
  parameter int DATA_W     = 304,
  parameter int CHUNK_W    = 16,
  parameter int NUM_CHUNKS = DATA_W / CHUNK_W,
  parameter int CNT_W      = $clog2(NUM_CHUNKS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [DATA_W-1:0]  data_in,
  output logic [CHUNK_W-1:0] data_out,
  output logic               valid_out,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    buf_q, buf_d;
  logic [CHUNK_W-1:0]   data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 done_q, done_d;
  logic                 capture;

  // The FSM returns to IDLE on the same edge that raises done; holding
  // ready low while done is up keeps the per-word period at 21 cycles.
  assign ready_out = (state_q == IDLE) && !done_q;
  assign capture   = ready_out && valid_in;

  assign data_out  = data_q;
  assign valid_out = vld_q;
  assign done      = done_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = SEND;
      SEND:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; data_out is zero whenever not valid
  always_comb begin
    cnt_d  = cnt_q;
    buf_d  = buf_q;
    data_d = '0;
    vld_d  = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          // Chunk 0 goes straight out; the buffer keeps chunks 1..18 at the top
          data_d = data_in[DATA_W-1 -: CHUNK_W];
          buf_d  = data_in << CHUNK_W;
          vld_d  = 1'b1;
          cnt_d  = CNT_W'(1);
        end
      end
      SEND: begin
        data_d = buf_q[DATA_W-1 -: CHUNK_W];
        buf_d  = buf_q << CHUNK_W;
        vld_d  = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      DONE: begin
        done_d = 1'b1;
        cnt_d  = '0;
        buf_d  = '0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset aborts any word in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      buf_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      buf_q  <= buf_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_output_module_304to16.sv
// Scoreboard bench for output_module_304to16: stimulus pushes expected
// chunks and done markers; a monitor pops and compares on every output.
module tb_output_module_304to16;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic         ready_out;
  logic [303:0] data_in;
  logic [15:0]  data_out;
  logic         valid_out;
  logic         done;

  output_module_304to16 dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // {is_done_marker, chunk}
  logic [16:0] exp_q[$];
  int          done_times[$];
  logic        prev_valid = 1'b0;
  int          run_len    = 0;

  logic [303:0] vecs[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge
  initial begin
    logic [16:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_valid = 1'b0;
        run_len    = 0;
      end else begin
        if (valid_out) begin
          chk("ready_low_while_busy", 32'(ready_out), 32'd0);
          chk("no_done_with_data", 32'(done), 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_chunk", 32'(data_out), 32'hdead_0000);
          end else begin
            e = exp_q.pop_front();
            chk("chunk_kind", 32'(e[16]), 32'd0);
            chk("chunk_data", 32'(data_out), 32'(e[15:0]));
          end
          run_len++;
        end else begin
          chk("data_zero_when_idle", 32'(data_out), 32'd0);
          if (done) begin
            chk("done_after_19_chunks", 32'(run_len), 32'd19);
            chk("done_follows_last_chunk", 32'(prev_valid), 32'd1);
            done_times.push_back(cyc);
            if (exp_q.size() == 0) begin
              chk("unexpected_done", 32'(done), 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("done_marker", 32'(e[16]), 32'd1);
            end
          end else if (prev_valid) begin
            chk("missing_done_after_stream", 32'(done), 32'd1);
          end
          run_len = 0;
        end
        prev_valid = valid_out;
      end
    end
  end

  task automatic push_word(input logic [303:0] v);
    for (int k = 0; k < 19; k++) exp_q.push_back({1'b0, v[303-16*k -: 16]});
    exp_q.push_back({1'b1, 16'h0000});
  endtask

  task automatic scramble_data();
    for (int i = 0; i < 19; i++) data_in[i*16 +: 16] = 16'($urandom);
  endtask

  // Called at a falling edge; returns at the falling edge after capture
  task automatic send_word(input logic [303:0] v);
    int n = 0;
    while (!ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      chk("ready_timeout", 32'(ready_out), 32'd1);
      return;
    end
    valid_in = 1'b1;
    data_in  = v;
    push_word(v);
    @(negedge clk);
    valid_in = 1'b0;
    scramble_data();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [303:0] v;
    int base;
    int n;

    vecs[0]  = {19{16'h0014}};
    vecs[1]  = {{6{16'h000f}}, {7{16'h0005}}, {6{16'h0014}}};
    vecs[2]  = {19{16'h0005}};
    vecs[3]  = {{10{16'h000f}}, {9{16'h0014}}};
    vecs[4]  = {{3{16'h0005}}, {3{16'h000f}}, {13{16'h0014}}};
    vecs[5]  = {{9{16'h000f, 16'h0005}}, 16'h0014};
    vecs[6]  = {{2{16'h0014}}, {17{16'h000f}}};
    vecs[7]  = {16'h000f, {17{16'h0005}}, 16'h0014};
    vecs[8]  = {19{16'h000f}};
    vecs[9]  = {{9{16'h0014, 16'h0005}}, 16'h000f};
    vecs[10] = {{4{16'h0005}}, {11{16'h0014}}, {4{16'h000f}}};
    vecs[11] = {{18{16'h0014}}, 16'h0005};
    vecs[12] = {16'h0005, {18{16'h0014}}};
    vecs[13] = {{7{16'h000f}}, {5{16'h0014}}, {7{16'h0005}}};
    vecs[14] = {{6{16'h000f, 16'h0014, 16'h0005}}, 16'h000f};
    vecs[15] = {19{16'h0005}};

    // Reset and idle
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    repeat (5) @(negedge clk);

    // Single word ordering
    v = {{3{16'h0014}}, {8{16'h000a}}, {8{16'h0014}}};
    send_word(v);
    wait_drain();
    @(negedge clk);
    chk("ready_after_word", 32'(ready_out), 32'd1);

    // Sixteen words back-to-back
    for (int i = 0; i < 16; i++) send_word(vecs[i]);
    wait_drain();

    // valid_in while busy is ignored
    send_word(vecs[8]);
    repeat (5) @(negedge clk);
    valid_in = 1'b1;
    data_in  = {19{16'hffff}};
    chk("busy_ready_low", 32'(ready_out), 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    scramble_data();
    wait_drain();
    repeat (5) @(negedge clk);

    // Reset mid-stream at chunk 10
    send_word(vecs[1]);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_valid", 32'(valid_out), 32'd0);
    chk("abort_data", 32'(data_out), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(ready_out), 32'd1);
    repeat (3) @(negedge clk);
    send_word(vecs[3]);
    wait_drain();

    // Held valid_in: three words, one capture per idle window
    base = done_times.size();
    valid_in = 1'b1;
    data_in  = vecs[4];
    for (int i = 0; i < 3; i++) push_word(vecs[4]);
    n = 0;
    while (done_times.size() < base + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    valid_in = 1'b0;
    chk("held_done_count", 32'(done_times.size() - base), 32'd3);
    if (done_times.size() >= base + 3) begin
      chk("held_period_1", 32'(done_times[base+1] - done_times[base]), 32'd21);
      chk("held_period_2", 32'(done_times[base+2] - done_times[base+1]), 32'd21);
    end
    wait_drain();
    repeat (30) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_ready", 32'(ready_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/output_module_304to16.md
Name: output_module_304to16

Overview:
- Parallel-to-serial output stage: accepts one 304-bit word (19 packed 16-bit samples) through a valid/ready handshake.
- Streams the word out as 19 consecutive 16-bit chunks, most-significant chunk first.
- Pulses done after the final chunk.
- Sits at the tail of the OFDM datapath, narrowing the wide symbol bus to a 16-bit output port.

Parameters:
- DATA_W, 304, input word width.
- CHUNK_W, 16, output chunk width.
- NUM_CHUNKS, 19, chunks per word (DATA_W / CHUNK_W); the counter width must hold NUM_CHUNKS-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  input word valid.
- ready_out  output  1  block idle and able to accept a word.
- data_in  input  304  packed input word; chunk k = data_in[303-16k -: 16].
- data_out  output  16  current output chunk.
- valid_out  output  1  data_out holds a valid chunk this cycle.
- done  output  1  one-cycle pulse after the last chunk of a word.

Behaviour:
- One clock; synchronous, active-high reset; all outputs registered except ready_out, which is decoded from state.
- States: IDLE, SEND, DONE.
- Reset (when reset=1 at a rising edge):
  - State goes to IDLE; chunk counter and shift buffer clear.
  - data_out=0, valid_out=0, done=0; ready_out=1 (IDLE).
  - Reset overrides all other inputs and aborts any word in flight; no further chunks or done follow.
- ready_out = 1 only in IDLE; 0 in SEND and DONE.
- Capture:
  - Occurs at a rising edge E where state=IDLE and valid_in=1.
  - Latches data_in into a 304-bit buffer.
  - Drives data_out <= data_in[303:288] and valid_out <= 1; counter <= 1; state -> SEND.
  - valid_in only needs to be high for that single edge.
- SEND:
  - At each edge E+k (k=1..18), data_out <= chunk k and valid_out stays 1.
  - Chunk k is therefore presented in the cycle following edge E+k, for k=0..18: exactly 19 consecutive valid cycles with no gaps.
  - The counter increments per chunk.
  - At edge E+18, after issuing chunk 18, state -> DONE.
- DONE:
  - At edge E+19: valid_out <= 0, data_out <= 0, done <= 1 (high for exactly one cycle); state -> IDLE.
  - At edge E+20: done <= 0, and ready_out is 1 again from this point.
- valid_in while busy:
  - valid_in asserted in SEND or DONE is ignored; no queuing.
  - data_in changes during SEND do not affect output (the buffer is used).
- data_out = 0 whenever valid_out = 0.
- Latency: first chunk visible one cycle after the capture edge; 19 cycles of data; done one cycle after the last chunk.
- Next-word timing:
  - A new word can be captured at the edge after done deasserts (IDLE).
  - Minimum per-word period is 21 cycles.
- No arithmetic on the data; bits pass through unchanged.

Test Plan:
- Reset then idle: hold reset 2 cycles, release -> ready_out=1, valid_out=0, done=0, data_out=0000; no activity without valid_in.
- Single word ordering: capture 304'h0014_0014_0014_000a×8_0014×8 -> 19 consecutive valid cycles with chunks 0014,0014,0014, then 000a ×8, then 0014 ×8; ready_out=0 throughout; done pulses once, one cycle after chunk 18; then ready_out=1.
- Back-to-back sixteen words:
  - Vectors: 0014…0014 uniform; 000f/0005/0014 mixes; 0005 uniform.
  - Each is loaded as soon as ready_out=1.
  - Each yields exactly 19 chunks matching its 16-bit slices MSB first, followed by one done pulse.
- valid_in while busy: assert valid_in with 304'hFFFF… during chunk 5 of a 000f-vector -> output stream unchanged, no second word started, ready_out stays 0.
- Reset mid-stream: assert reset during chunk 10 -> next cycle valid_out=0, data_out=0000, no done pulse, ready_out=1; a following word streams correctly from chunk 0.
- Held valid_in: keep valid_in=1 continuously -> words captured only at edges in IDLE; every word produces 19 chunks + done with one-cycle idle gap.
